// File: rtl/dma_xfer_splitter_pkg.sv
// Shared types and defaults for the DMA transaction splitter and related walkers.
// Command records carry 32-bit fields; the splitter itself is parametrised independently.
package dma_xfer_splitter_pkg;

  localparam int DMA_MAX_XFER_BYTES = 2048;
  localparam int DMA_BOUNDARY_BYTES = 4096;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } split_state_e;

  typedef struct packed {
    logic [31:0] NumBytes;
    logic [31:0] SrcAddr;
    logic [31:0] DestAddr;
    logic        DestFixed;
  } XferSplitCmd_t;

  typedef struct packed {
    logic [31:0] NumBytes;
    logic [31:0] SrcAddr;
    logic [31:0] DestAddr;
    logic        Last;
  } XferCmd_t;

endpackage

// File: rtl/dma_xfer_splitter_chunk_calc.sv
// Combinational chunk sizing: smallest of remaining bytes, the per-transfer cap and the
// room left before the next boundary on the source and (unless fixed) destination side.
module dma_chunk_calc #(
  parameter int  MAX_XFER_BYTES = 2048,
  parameter int  BOUNDARY_BYTES = 4096,
  parameter int  TLEN_W         = 32,
  localparam int BND_W          = $clog2(BOUNDARY_BYTES),
  localparam int XLEN_W         = $clog2(MAX_XFER_BYTES + 1)
) (
  input  logic [BND_W-1:0]  src_low_i,
  input  logic [BND_W-1:0]  dest_low_i,
  input  logic [TLEN_W-1:0] remain_i,
  input  logic              dest_fix_i,
  output logic [XLEN_W-1:0] chunk_o,
  output logic              last_o
);

  // Wide enough for both the full remaining count and a whole boundary window.
  localparam int CW = (TLEN_W > BND_W + 1) ? TLEN_W : BND_W + 1;

  logic [CW-1:0] src_room;
  logic [CW-1:0] dest_room;
  logic [CW-1:0] chunk_w;

  always_comb begin
    src_room  = CW'(BOUNDARY_BYTES) - CW'(src_low_i);
    dest_room = CW'(BOUNDARY_BYTES) - CW'(dest_low_i);
    chunk_w   = CW'(remain_i);
    if (chunk_w > CW'(MAX_XFER_BYTES)) chunk_w = CW'(MAX_XFER_BYTES);
    if (chunk_w > src_room) chunk_w = src_room;
    if (!dest_fix_i && (chunk_w > dest_room)) chunk_w = dest_room;
    chunk_o = XLEN_W'(chunk_w);
    last_o  = (chunk_w == CW'(remain_i));
  end

endmodule

// File: rtl/dma_xfer_splitter.sv
// Splits one (src, dest, bytes) transaction into capped, boundary-safe transfer commands.
// Handshakes: a transfer retires on xfer_valid & xfer_ready; xfer_* hold while valid & !ready.
module dma_xfer_splitter
  import dma_xfer_splitter_pkg::*;
#(
  parameter int  ADDR_W         = 32,
  parameter int  TLEN_W         = 32,
  parameter int  MAX_XFER_BYTES = DMA_MAX_XFER_BYTES,
  parameter int  BOUNDARY_BYTES = DMA_BOUNDARY_BYTES,
  localparam int XLEN_W         = $clog2(MAX_XFER_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trans_valid,
  output logic              trans_ready,
  input  logic [ADDR_W-1:0] trans_src,
  input  logic [ADDR_W-1:0] trans_dest,
  input  logic [TLEN_W-1:0] trans_bytes,
  input  logic              trans_dest_fix,
  output logic              xfer_valid,
  input  logic              xfer_ready,
  output logic [ADDR_W-1:0] xfer_src,
  output logic [ADDR_W-1:0] xfer_dest,
  output logic [XLEN_W-1:0] xfer_bytes,
  output logic              xfer_last,
  output logic              trans_done,
  output logic              busy,
  output split_state_e      dbg_state
);

  localparam int BND_W = $clog2(BOUNDARY_BYTES);

  split_state_e      state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [TLEN_W-1:0] remain_q, remain_d;
  logic              fix_q, fix_d;
  logic              done_q, done_d;

  logic [XLEN_W-1:0] chunk;
  logic              chunk_last;

  dma_chunk_calc #(
    .MAX_XFER_BYTES (MAX_XFER_BYTES),
    .BOUNDARY_BYTES (BOUNDARY_BYTES),
    .TLEN_W         (TLEN_W)
  ) u_chunk_calc (
    .src_low_i  (src_q[BND_W-1:0]),
    .dest_low_i (dest_q[BND_W-1:0]),
    .remain_i   (remain_q),
    .dest_fix_i (fix_q),
    .chunk_o    (chunk),
    .last_o     (chunk_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dest_q   <= '0;
      remain_q <= '0;
      fix_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dest_q   <= dest_d;
      remain_q <= remain_d;
      fix_q    <= fix_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dest_d   = dest_q;
    remain_d = remain_q;
    fix_d    = fix_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trans_valid) begin
          // A zero-length transaction is acknowledged without ever issuing a transfer.
          if (trans_bytes == '0) begin
            done_d = 1'b1;
          end else begin
            src_d    = trans_src;
            dest_d   = trans_dest;
            remain_d = trans_bytes;
            fix_d    = trans_dest_fix;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (xfer_ready) begin
          src_d    = src_q + ADDR_W'(chunk);
          if (!fix_q) dest_d = dest_q + ADDR_W'(chunk);
          remain_d = remain_q - TLEN_W'(chunk);
          if (chunk_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign trans_ready = (state_q == ST_IDLE);
  assign xfer_valid  = (state_q == ST_ISSUE);
  assign busy        = (state_q == ST_ISSUE);
  assign xfer_src    = src_q;
  assign xfer_dest   = dest_q;
  assign xfer_bytes  = chunk;
  assign xfer_last   = chunk_last;
  assign trans_done  = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dma_xfer_splitter.sv
// Randomised and directed bench for dma_xfer_splitter with a queue-based scoreboard.
// Expected transfers come from a plain arithmetic model of the splitting rules.
module tb_dma_xfer_splitter;
  import dma_xfer_splitter_pkg::*;

  localparam int ADDR_W = 32;
  localparam int TLEN_W = 32;
  localparam int MAXB   = 2048;
  localparam int BND    = 4096;
  localparam int XLEN_W = $clog2(MAXB + 1);
  localparam int W      = 2 * ADDR_W + XLEN_W + 1;

  logic              clk;
  logic              rst;
  logic              trans_valid;
  logic              trans_ready;
  logic [ADDR_W-1:0] trans_src;
  logic [ADDR_W-1:0] trans_dest;
  logic [TLEN_W-1:0] trans_bytes;
  logic              trans_dest_fix;
  logic              xfer_valid;
  logic              xfer_ready;
  logic [ADDR_W-1:0] xfer_src;
  logic [ADDR_W-1:0] xfer_dest;
  logic [XLEN_W-1:0] xfer_bytes;
  logic              xfer_last;
  logic              trans_done;
  logic              busy;
  split_state_e      dbg_state;

  dma_xfer_splitter #(
    .ADDR_W         (ADDR_W),
    .TLEN_W         (TLEN_W),
    .MAX_XFER_BYTES (MAXB),
    .BOUNDARY_BYTES (BND)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .trans_valid    (trans_valid),
    .trans_ready    (trans_ready),
    .trans_src      (trans_src),
    .trans_dest     (trans_dest),
    .trans_bytes    (trans_bytes),
    .trans_dest_fix (trans_dest_fix),
    .xfer_valid     (xfer_valid),
    .xfer_ready     (xfer_ready),
    .xfer_src       (xfer_src),
    .xfer_dest      (xfer_dest),
    .xfer_bytes     (xfer_bytes),
    .xfer_last      (xfer_last),
    .trans_done     (trans_done),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int           exp_done_q[$];
  int           retire_cnt = 0;

  // 0: always ready, 1: random, 2: held low; pulse_req forces one ready cycle.
  int rdy_mode  = 0;
  int pulse_req = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Reference model: split using the rules directly.
  task automatic model_push(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dest,
                            input logic [TLEN_W-1:0] bytes, input bit fix);
    longint rem, c, room;
    logic [ADDR_W-1:0] s, d;
    logic [XLEN_W-1:0] cb;
    rem = longint'(bytes);
    s = src;
    d = dest;
    while (rem > 0) begin
      c = rem;
      if (c > MAXB) c = MAXB;
      room = BND - (longint'(s) % BND);
      if (c > room) c = room;
      if (!fix) begin
        room = BND - (longint'(d) % BND);
        if (c > room) c = room;
      end
      cb = XLEN_W'(c);
      exp_q.push_back({s, d, cb, (c == rem)});
      s = s + ADDR_W'(c);
      if (!fix) d = d + ADDR_W'(c);
      rem = rem - c;
    end
  endtask

  // ---------------- ready generator ----------------
  int pulse_seen = 0;
  always @(posedge clk) begin
    #1;
    if (pulse_req != pulse_seen) begin
      xfer_ready = 1'b1;
      pulse_seen = pulse_req;
    end else if (rdy_mode == 1) begin
      xfer_ready = ($urandom_range(0, 3) != 0);
    end else begin
      xfer_ready = (rdy_mode == 0);
    end
  end

  // ---------------- monitor ----------------
  logic         hold_prev = 1'b0;
  logic [W-1:0] prev_cur;
  always @(negedge clk) begin
    logic [W-1:0] cur;
    logic [W-1:0] e;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      cur = {xfer_src, xfer_dest, xfer_bytes, xfer_last};
      check("ready_vs_busy", trans_ready, !busy);
      if (hold_prev) begin
        check("stall_valid_held", xfer_valid, 1'b1);
        check("stall_fields_held", cur, prev_cur);
      end
      if (xfer_valid && xfer_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got %h expected none (cycle %0d)", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          check("xfer_fields", cur, e);
          if (e[0]) exp_done_q.push_back(cyc + 1);
          retire_cnt++;
        end
      end
      hold_prev = xfer_valid && !xfer_ready;
      prev_cur  = cur;
      if (exp_done_q.size() > 0 && exp_done_q[0] == cyc) begin
        void'(exp_done_q.pop_front());
        check("trans_done_pulse", trans_done, 1'b1);
        check("ready_at_done", trans_ready, 1'b1);
      end else if (trans_done) begin
        check("trans_done_unexpected", trans_done, 1'b0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dest,
                      input logic [TLEN_W-1:0] bytes, input bit fix);
    int n = 0;
    @(negedge clk);
    while (!trans_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!trans_ready) fail_now("wait_trans_ready");
    trans_src      = src;
    trans_dest     = dest;
    trans_bytes    = bytes;
    trans_dest_fix = fix;
    trans_valid    = 1'b1;
    model_push(src, dest, bytes, fix);
    if (bytes == '0) exp_done_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    trans_valid = 1'b0;
    trans_src   = $urandom;
    trans_bytes = $urandom;
    @(negedge clk);
    if (bytes != '0) begin
      check("first_xfer_valid", xfer_valid, 1'b1);
      check("busy_after_accept", busy, 1'b1);
    end else begin
      check("zero_len_no_xfer", xfer_valid, 1'b0);
      check("zero_len_ready", trans_ready, 1'b1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp_done_q.size() != 0 || !trans_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail_now("wait_idle");
    exp_q.delete();
    exp_done_q.delete();
  endtask

  task automatic wait_retire(input int target);
    int n = 0;
    while (retire_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (retire_cnt < target) fail_now("wait_retire");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [ADDR_W-1:0] rs, rd;
    logic [TLEN_W-1:0] rb;
    int base;
    rst            = 1'b1;
    trans_valid    = 1'b0;
    trans_src      = '0;
    trans_dest     = '0;
    trans_bytes    = '0;
    trans_dest_fix = 1'b0;
    xfer_ready     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_trans_ready", trans_ready, 1'b1);
    check("rst_xfer_valid", xfer_valid, 1'b0);
    check("rst_trans_done", trans_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases
    send(32'h0FF0, 32'h2000, 32'h40, 1'b0);
    wait_idle();
    send(32'h0, 32'h0, 32'd5000, 1'b0);
    wait_idle();
    send(32'h0, 32'h0FFC, 32'd4096, 1'b1);
    wait_idle();

    // Stall mid-sequence
    base = retire_cnt;
    send(32'h0, 32'h0, 32'd5000, 1'b0);
    wait_retire(base + 1);
    rdy_mode = 2;
    repeat (6) @(negedge clk);
    rdy_mode = 0;
    wait_idle();

    send(32'h123, 32'h456, 32'd0, 1'b0);
    wait_idle();

    // Reset while the second transfer is presented
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    base = retire_cnt;
    send(32'h0, 32'h0, 32'd5000, 1'b0);
    pulse_req++;
    wait_retire(base + 1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    exp_done_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_xfer_valid", xfer_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_trans_ready", trans_ready, 1'b1);
    rdy_mode = 0;
    send(32'h0FF0, 32'h2000, 32'h40, 1'b0);
    wait_idle();

    // Randomised transactions with random back-pressure
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      rs = $urandom;
      rd = $urandom;
      if ($urandom_range(0, 2) == 0) rs[11:0] = 12'hFFF - 12'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) rd = 32'hFFFF_F000 + 32'($urandom_range(0, 4095));
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 16));
        default: rb = 32'($urandom_range(1, 10000));
      endcase
      send(rs, rd, rb, 1'($urandom_range(0, 1)));
      wait_idle();
    end
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
